fmul_arb: RTL and testbench
===========================

# fmul_arb

Two-port arbiter and sequencer for the shared iterative single-precision multiplier `fmul` / `vscale_mul_div` in FML mode. It accepts multiply requests from two clients over valid/ready handshakes and grants them round-robin. It issues one operation at a time to the non-pipelined multiplier, waits for its response, and returns result and IEEE flags to the originating client with backpressure.

## Interface
- `RR_INIT`, default 0: client holding priority after reset (0 or 1).
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req0_valid` in 1: client 0 operation pending.
- `req0_ready` out 1: client 0 operation accepted this cycle.
- `req0_x`, `req0_y` in 32: client 0 operands, IEEE single.
- `rsp0_valid` out 1: client 0 result available.
- `rsp0_ready` in 1: client 0 takes result.
- `rsp0_rslt` out 32: result.
- `rsp0_flag` out 5: {NV,DZ,OF,UF,NX}, same order as multiplier `flag`.
- `req1_*`, `rsp1_*`: identical set for client 1.
- `mul_req` out 1: one-cycle start pulse to multiplier.
- `mul_x`, `mul_y` out 32: operands to multiplier.
- `mul_resp_valid` in 1: multiplier result valid (single-cycle pulse).
- `mul_rslt` in 32, `mul_flag` in 5: multiplier result and flags.

## Operation
- State machine: IDLE, ISSUE, BUSY, RESP. Registers: `opx`, `opy`, `tag` (owning client), `prio`, `res`, `flg`.
- IDLE: grant = `prio` client if its valid is high, else the other client if its valid is high. The granted client's `reqN_ready` = 1 combinationally. Only one ready is ever high. Ready is 0 in all other states.
- On accept: latch operands and `tag`. Next state is ISSUE, or RESP for the fast path (see Configuration).
- ISSUE: `mul_req`=1 for exactly this cycle; `mul_x`/`mul_y` = `opx`/`opy`. Next state BUSY.
- BUSY: wait, with no timeout. On `mul_resp_valid`, capture `mul_rslt`/`mul_flag` into `res`/`flg`; next state RESP.
- RESP: `rsp[tag]_valid`=1; the other client's `rsp_valid`=0. On `rsp[tag]_ready`: next state IDLE, `prio` <= ~`tag`. The result stays stable until accepted.
- `rspN_rslt`/`rspN_flag` both drive `res`/`flg`; they are qualified only by the matching valid.
- `mul_x`/`mul_y` hold `opx`/`opy` in all states; they are only meaningful with `mul_req`.
- `mul_resp_valid` outside BUSY is ignored and captures nothing, including a stray response after a reset mid-operation.
- Priority changes only on response hand-off, never on accept.

## Timing
- Reset: state IDLE; `prio`=`RR_INIT`; `tag`=0; `res`=0; `flg`=0; `mul_req`=0; all `reqN_ready`/`rspN_valid`=0 from the first cycle after reset.
- Accept at edge t: `mul_req` high in cycle t+1. If the multiplier responds in cycle t+1+L, `rsp_valid` rises in cycle t+2+L.
- Minimum accept-to-accept interval = multiplier latency + 3 cycles (ISSUE, capture, RESP hand-off). Next accept is possible in the cycle after `rsp_ready` is sampled.
- Both clients valid in IDLE: the `prio` client wins; the loser's valid/operands must stay held (standard valid/ready; no drop).
- Reset during BUSY/RESP: the operation is abandoned and no response is delivered. The client must re-request.

## Configuration
- `FMUL_ARB_ZERO_EN` defined: on accept, if both operands have exponent != 8'hff and either operand has bits [30:0]==0, the multiplier is bypassed. `res` = {x[31]^y[31], 31'h0}, `flg`=5'h0, next state RESP directly, and `mul_req` never pulses. Accept-to-`rsp_valid` latency = 1 cycle.
- Undefined: every operation goes through ISSUE/BUSY. Zero results come from the multiplier.

## Test plan
- Client 0 sends 0x3fc00000 × 0x40000000 -> exactly one `mul_req` pulse with those operands; `rsp0_valid` with 0x40400000, flag 0; client 1 `rsp1_valid` stays 0.
- Both valid in the same cycle after reset (`RR_INIT`=0) -> client 0 served first, then client 1 with no intervening idle client 0 request. Repeat both valid -> client 0 served again (strict alternation).
- `rsp1_ready` held low for 10 cycles -> `rsp1_valid`/`rslt`/`flag` stable, `req0_ready`=0 throughout; release -> IDLE next cycle.
- With `FMUL_ARB_ZERO_EN`: 0x80000000 × 0x40400000 -> 0x80000000, flag 0, 1 cycle, no `mul_req`. 0x00000000 × 0x7f800000 -> goes to multiplier, returns 0xffc00000 flag 0x10.
- `reset` asserted in BUSY, then a `mul_resp_valid` pulse arrives in IDLE -> no `rsp_valid` on either port; the next request completes normally.

Source files
------------

// File: rtl/fmul_arb.sv
// fmul_arb: round-robin two-client front end for the shared iterative FP multiplier.
// Optional build macro FMUL_ARB_ZERO_EN answers finite x zero products locally, bypassing the multiplier.
module fmul_arb #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_rslt,
  output logic [4:0]  rsp0_flag,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_rslt,
  output logic [4:0]  rsp1_flag,
  output logic        mul_req,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic        mul_resp_valid,
  input  logic [31:0] mul_rslt,
  input  logic [4:0]  mul_flag
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t      state;
  logic [31:0] opx;
  logic [31:0] opy;
  logic [31:0] res;
  logic [4:0]  flg;
  logic        tag;
  logic        prio;
  logic        mul_req_q;

  logic        grant0;
  logic        grant1;
  logic        acc;
  logic        acc_tag;
  logic [31:0] acc_x;
  logic [31:0] acc_y;
  logic        zero_byp;
  logic        rsp_take;

  // The priority client wins a tie; the other only gets through when the priority client is quiet.
  always_comb begin
    grant0     = req0_valid && (!prio || !req1_valid);
    grant1     = req1_valid && (prio || !req0_valid);
    req0_ready = (state == IDLE) && !reset && grant0;
    req1_ready = (state == IDLE) && !reset && grant1;
    acc        = req0_ready || req1_ready;
    acc_tag    = req1_ready;
    acc_x      = acc_tag ? req1_x : req0_x;
    acc_y      = acc_tag ? req1_y : req0_y;
    rsp_take   = tag ? rsp1_ready : rsp0_ready;
  end

`ifdef FMUL_ARB_ZERO_EN
  // Infinity/NaN operands still go to the multiplier so it can raise NV or propagate the NaN.
  assign zero_byp = (acc_x[30:23] != 8'hff) && (acc_y[30:23] != 8'hff) &&
                    ((acc_x[30:0] == 31'h0) || (acc_y[30:0] == 31'h0));
`else
  assign zero_byp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= RR_INIT;
      tag       <= 1'b0;
      res       <= 32'h0;
      flg       <= 5'h0;
      opx       <= 32'h0;
      opy       <= 32'h0;
      mul_req_q <= 1'b0;
    end else begin
      mul_req_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc) begin
            opx <= acc_x;
            opy <= acc_y;
            tag <= acc_tag;
            if (zero_byp) begin
              res   <= {acc_x[31] ^ acc_y[31], 31'h0};
              flg   <= 5'h0;
              state <= RESP;
            end else begin
              mul_req_q <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= BUSY;
        BUSY: begin
          if (mul_resp_valid) begin
            res   <= mul_rslt;
            flg   <= mul_flag;
            state <= RESP;
          end
        end
        RESP: begin
          // Rotation happens at hand-off so a stalled consumer cannot lose its turn.
          if (rsp_take) begin
            prio  <= ~tag;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_req    = mul_req_q;
  assign mul_x      = opx;
  assign mul_y      = opy;
  assign rsp0_valid = (state == RESP) && !tag;
  assign rsp1_valid = (state == RESP) && tag;
  assign rsp0_rslt  = res;
  assign rsp0_flag  = flg;
  assign rsp1_rslt  = res;
  assign rsp1_flag  = flg;

endmodule

// File: tb/tb_fmul_arb.sv
// Bench for fmul_arb: directed vector table, hand-written corner sequences, then randomized traffic
// against a transaction-level model with a behavioural multiplier of random latency.
module tb_fmul_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_rslt, rsp1_rslt;
  logic [4:0]  rsp0_flag, rsp1_flag;
  logic        mul_req;
  logic [31:0] mul_x, mul_y;
  logic        mul_resp_valid = 1'b0;
  logic [31:0] mul_rslt = '0;
  logic [4:0]  mul_flag = '0;

`ifdef FMUL_ARB_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  fmul_arb #(.RR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rslt(rsp0_rslt), .rsp0_flag(rsp0_flag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rslt(rsp1_rslt), .rsp1_flag(rsp1_flag),
    .mul_req(mul_req), .mul_x(mul_x), .mul_y(mul_y),
    .mul_resp_valid(mul_resp_valid), .mul_rslt(mul_rslt), .mul_flag(mul_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: a few genuine IEEE products, a scrambling hash otherwise.
  function automatic logic [36:0] mfun(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h3fc00000, 32'h40000000}: return {5'h00, 32'h40400000};
      {32'h00000000, 32'h7f800000}: return {5'h10, 32'hffc00000};
      {32'h80000000, 32'h40400000}: return {5'h00, 32'h80000000};
      {32'h7f7fffff, 32'h40000000}: return {5'h05, 32'h7f800000};
      {32'hbf800000, 32'h40400000}: return {5'h00, 32'hc0400000};
      default: return {x[4:0] ^ y[9:5], (x ^ {y[15:0], y[31:16]}) + 32'h1357};
    endcase
  endfunction

  function automatic bit byp_ref(input logic [31:0] x, input logic [31:0] y);
    return ZEN && (x[30:23] != 8'hff) && (y[30:23] != 8'hff) && (x[30:0] == 0 || y[30:0] == 0);
  endfunction

  function automatic logic [36:0] exp_res(input logic [31:0] x, input logic [31:0] y);
    if (byp_ref(x, y)) return {5'h0, x[31] ^ y[31], 31'h0};
    return mfun(x, y);
  endfunction

  int          mlat = 2;
  int          cd = 0;
  int          n_mulreq = 0;
  logic [31:0] mx = '0, my = '0;
  bit          prev_req = 1'b0;

  always @(negedge clk) begin
    mul_resp_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        {mul_flag, mul_rslt} = mfun(mx, my);
        mul_resp_valid = 1'b1;
      end
    end
    if (mul_req === 1'b1) begin
      chk("mul_req_single_pulse_and_idle_mul", {62'h0, prev_req, cd != 0}, 64'h0);
      n_mulreq++;
      mx = mul_x;
      my = mul_y;
      cd = mlat;
    end
    prev_req = (mul_req === 1'b1);
  end

  task automatic set_req(input bit c, input bit v, input logic [31:0] x, input logic [31:0] y);
    if (c) begin req1_valid = v; req1_x = x; req1_y = y; end
    else begin req0_valid = v; req0_x = x; req0_y = y; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic accept(input bit c, input logic [31:0] x, input logic [31:0] y, output int w);
    bit got = 1'b0;
    w = 0;
    set_req(c, 1'b1, x, y);
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((c ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else begin w++; @(posedge clk); #1; end
    end
    chk("accept_seen", {63'h0, got}, 64'h1);
    @(posedge clk); #1;
    set_req(c, 1'b0, x, y);
  endtask

  // Counts cycles until rsp_valid on port c, checks the payload, then hands off.
  task automatic wait_rsp(input bit c, input logic [36:0] ev, output int lat);
    bit seen = 1'b0;
    bit other = 1'b0;
    lat = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if ((c ? rsp0_valid : rsp1_valid) !== 1'b0) other = 1'b1;
      if ((c ? rsp1_valid : rsp0_valid) === 1'b1) seen = 1'b1;
    end
    chk("rsp_seen", {63'h0, seen}, 64'h1);
    chk("rsp_other_port_quiet", {63'h0, other}, 64'h0);
    if (seen) begin
      chk("rsp_payload", c ? {rsp1_flag, rsp1_rslt} : {rsp0_flag, rsp0_rslt}, ev);
      if (c) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  typedef struct {
    bit          c;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    logic [31:0] rslt;
    logic [4:0]  flg;
    bit          byp;
  } vec_t;

  initial begin
    vec_t        vt[5];
    int          w, lat, n0;
    bit          bad;
    logic [31:0] hr;
    logic [4:0]  hf;

    vt[0] = '{1'b0, 32'h3fc00000, 32'h40000000, 3, 32'h40400000, 5'h00, 1'b0};
    vt[1] = '{1'b1, 32'h7f7fffff, 32'h40000000, 1, 32'h7f800000, 5'h05, 1'b0};
    vt[2] = '{1'b0, 32'h80000000, 32'h40400000, 4, 32'h80000000, 5'h00, 1'b1};
    vt[3] = '{1'b1, 32'h00000000, 32'h7f800000, 2, 32'hffc00000, 5'h10, 1'b0};
    vt[4] = '{1'b1, 32'hbf800000, 32'h40400000, 6, 32'hc0400000, 5'h00, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_ready", {62'h0, req0_ready, req1_ready}, 64'h0);
    chk("reset_rsp_valid", {62'h0, rsp0_valid, rsp1_valid}, 64'h0);
    chk("reset_mul_req", {63'h0, mul_req}, 64'h0);
    chk("reset_res_flg", {rsp0_flag, rsp0_rslt}, 64'h0);
    @(posedge clk); #1;

    // Simultaneous requests: client 0 keeps a second op queued throughout.
    mlat = 2;
    set_req(0, 1'b1, 32'h11111111, 32'h22222222);
    set_req(1, 1'b1, 32'h33333333, 32'h44444444);
    @(negedge clk);
    chk("tie_grant_after_reset", {62'h0, req0_ready, req1_ready}, 64'h2);
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h55555555, 32'h66666666);
    wait_rsp(0, mfun(32'h11111111, 32'h22222222), lat);
    @(negedge clk);
    chk("alternate_to_client1", {62'h0, req0_ready, req1_ready}, 64'h1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0, 32'h0);
    wait_rsp(1, mfun(32'h33333333, 32'h44444444), lat);
    set_req(1, 1'b1, 32'h77777777, 32'h88888888);
    @(negedge clk);
    chk("alternate_back_to_client0", {62'h0, req0_ready, req1_ready}, 64'h2);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, mfun(32'h55555555, 32'h66666666), lat);
    @(negedge clk);
    chk("alternate_client1_again", {62'h0, req0_ready, req1_ready}, 64'h1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'h0, 32'h0);
    wait_rsp(1, mfun(32'h77777777, 32'h88888888), lat);

    for (int i = 0; i < 5; i++) begin
      mlat = vt[i].lat;
      n0 = n_mulreq;
      accept(vt[i].c, vt[i].x, vt[i].y, w);
      chk("accept_when_idle", 64'(w), 64'h0);
      wait_rsp(vt[i].c, {vt[i].flg, vt[i].rslt}, lat);
      chk("accept_to_rsp_latency", 64'(lat), 64'((ZEN && vt[i].byp) ? 1 : 2 + vt[i].lat));
      chk("mul_req_count", 64'(n_mulreq - n0), 64'((ZEN && vt[i].byp) ? 0 : 1));
      if (!(ZEN && vt[i].byp)) chk("mul_operands", {mx, my}, {vt[i].x, vt[i].y});
    end

    // Consumer stall on client 1 while client 0 waits.
    mlat = 3;
    accept(1, 32'h7f7fffff, 32'h40000000, w);
    set_req(0, 1'b1, 32'h3fc00000, 32'h40000000);
    bad = 1'b1;
    for (int i = 0; i < 40 && bad; i++) begin
      @(negedge clk);
      if (rsp1_valid === 1'b1) bad = 1'b0;
    end
    chk("stall_rsp_seen", {63'h0, bad}, 64'h0);
    hr = rsp1_rslt;
    hf = rsp1_flag;
    chk("stall_payload", {hf, hr}, {5'h05, 32'h7f800000});
    for (int k = 0; k < 10; k++) begin
      if (!(rsp1_valid === 1'b1 && rsp1_rslt === hr && rsp1_flag === hf && req0_ready === 1'b0)) bad = 1'b1;
      @(negedge clk);
    end
    chk("stall_output_stable", {63'h0, bad}, 64'h0);
    rsp1_ready = 1'b1;
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_release", {62'h0, req0_ready, rsp1_valid}, 64'h2);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, {5'h00, 32'h40400000}, lat);

    // Reset while BUSY; the late multiplier response must be ignored.
    mlat = 5;
    accept(0, 32'hbf800000, 32'h40400000, w);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) bad = 1'b1;
    end
    chk("no_rsp_after_abort", {63'h0, bad}, 64'h0);
    chk("stray_resp_not_captured", {rsp0_flag, rsp0_rslt}, 64'h0);
    @(posedge clk); #1;
    mlat = 2;
    accept(0, 32'h3fc00000, 32'h40000000, w);
    wait_rsp(0, {5'h00, 32'h40400000}, lat);
    chk("post_abort_latency", 64'(lat), 64'h4);

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      bit          inflight = 1'b0;
      bit          own = 1'b0;
      bit          prio_ref = 1'b0;
      bit          acc0, acc1;
      logic [31:0] ex = '0, ey = '0;
      logic [36:0] ev = '0;
      logic [1:0]  vv;
      int          busy = 0;
      int          n_ops = 0;
      logic [31:0] pool[6];
      pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h7f800000;
      pool[3] = 32'hff800000; pool[4] = 32'h7fc00000; pool[5] = 32'h3f800000;
      acc0 = 1'b0;
      acc1 = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        if (!req0_valid && $urandom_range(0, 2) == 0)
          set_req(0, 1'b1, ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom,
                  ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom);
        if (!req1_valid && $urandom_range(0, 2) == 0)
          set_req(1, 1'b1, ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom,
                  ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom);
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        mlat = $urandom_range(1, 6);
        @(negedge clk);
        acc0 = (req0_ready === 1'b1);
        acc1 = (req1_ready === 1'b1);
        vv = {rsp1_valid, rsp0_valid};
        if (vv != 2'b00) begin
          chk("rnd_rsp_port", {61'h0, inflight, vv}, {61'h0, 1'b1, own ? 2'b10 : 2'b01});
          chk("rnd_rsp_payload", own ? {rsp1_flag, rsp1_rslt} : {rsp0_flag, rsp0_rslt}, ev);
          if (!byp_ref(ex, ey)) chk("rnd_mul_operands", {mx, my}, {ex, ey});
          if ((own ? rsp1_ready : rsp0_ready) && inflight) begin
            inflight = 1'b0;
            prio_ref = ~own;
          end
        end
        if (!inflight && (req0_valid || req1_valid) && vv == 2'b00) begin
          own = (req0_valid && req1_valid) ? prio_ref : req1_valid;
          chk("rnd_grant", {62'h0, acc0, acc1}, own ? 64'h1 : 64'h2);
          if (acc0 || acc1) begin
            inflight = 1'b1;
            ex = own ? req1_x : req0_x;
            ey = own ? req1_y : req0_y;
            ev = exp_res(ex, ey);
            busy = 0;
            n_ops++;
          end
        end else begin
          chk("rnd_no_ready", {62'h0, acc0, acc1}, 64'h0);
        end
        if (inflight) busy++;
        if (busy > 100) begin
          chk("rnd_stall_bound", 64'(busy), 64'h0);
          break;
        end
        @(posedge clk); #1;
      end
      chk("rnd_enough_ops", {63'h0, n_ops > 100}, 64'h1);
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
